// File: rtl/icache_axi_read_bridge.sv
// icache_axi_read_bridge: turns one I-cache line refill request into a single-ID
// AXI4 INCR read burst and hands each R beat back to the cache one cycle later.
module icache_axi_read_bridge #(
    parameter int         ADDR_W = 32,
    parameter int         DATA_W = 64,
    parameter int         BEATS  = 2,
    parameter logic [3:0] AXI_ID = 4'd0
) (
    input  logic              clock,
    input  logic              reset,
    // I-cache refill side
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_rdy,
    output logic              ret_valid,
    output logic              ret_last,
    output logic [DATA_W-1:0] ret_data,
    // AXI AR channel
    output logic              arvalid,
    input  logic              arready,
    output logic [ADDR_W-1:0] araddr,
    output logic [3:0]        arid,
    output logic [7:0]        arlen,
    output logic [2:0]        arsize,
    output logic [1:0]        arburst,
    // AXI R channel
    input  logic              rvalid,
    output logic              rready,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rlast,
    input  logic [3:0]        rid,
    output logic              bus_err
);
    localparam int LINE_BYTES = BEATS * DATA_W / 8;
    localparam int OFF_W      = $clog2(LINE_BYTES);
    localparam int CNT_W      = $clog2(BEATS) + 1;

    typedef enum logic [1:0] {IDLE, AR, R} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] araddr_q, araddr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] ret_data_q, ret_data_d;
    logic              ret_valid_q, ret_valid_d;
    logic              ret_last_q, ret_last_d;
    logic              bus_err_q, bus_err_d;
    logic [CNT_W-1:0]  cnt_inc;
    logic              count_done;
    logic              final_beat;
    logic              unused_bits;

    assign cnt_inc    = cnt_q + CNT_W'(1);
    assign count_done = (cnt_inc == CNT_W'(BEATS));

    // rid is never checked and the line offset bits are always forced to zero.
    assign unused_bits = ^{rid, rd_addr[OFF_W-1:0]};

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            araddr_q    <= '0;
            cnt_q       <= '0;
            ret_data_q  <= '0;
            ret_valid_q <= 1'b0;
            ret_last_q  <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            araddr_q    <= araddr_d;
            cnt_q       <= cnt_d;
            ret_data_q  <= ret_data_d;
            ret_valid_q <= ret_valid_d;
            ret_last_q  <= ret_last_d;
            bus_err_q   <= bus_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        araddr_d    = araddr_q;
        cnt_d       = cnt_q;
        ret_data_d  = ret_data_q;
        ret_valid_d = 1'b0;
        ret_last_d  = 1'b0;
        bus_err_d   = bus_err_q;
        final_beat  = 1'b0;
        rd_rdy      = 1'b0;
        arvalid     = 1'b0;
        rready      = 1'b0;

        unique case (state_q)
            IDLE: begin
                rd_rdy = 1'b1;
                if (rd_req) begin
                    araddr_d = {rd_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
                    cnt_d    = '0;
                    state_d  = AR;
                end
            end
            AR: begin
                arvalid = 1'b1;
                if (arready) begin
                    state_d = R;
                end
            end
            R: begin
                rready = 1'b1;
                if (rvalid) begin
                    // A burst that runs to BEATS without rlast is closed here and flagged.
                    final_beat  = rlast || count_done;
                    ret_data_d  = rdata;
                    ret_valid_d = 1'b1;
                    ret_last_d  = final_beat;
                    cnt_d       = cnt_inc;
                    if ((rresp != 2'b00) || (!rlast && count_done)) begin
                        bus_err_d = 1'b1;
                    end
                    if (final_beat) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign araddr    = araddr_q;
    assign ret_data  = ret_data_q;
    assign ret_valid = ret_valid_q;
    assign ret_last  = ret_last_q;
    assign bus_err   = bus_err_q;
    assign arid      = AXI_ID;
    assign arlen     = 8'(BEATS - 1);
    assign arsize    = 3'($clog2(DATA_W / 8));
    assign arburst   = 2'b01;

endmodule

// File: tb/tb_icache_axi_read_bridge.sv
// Self-checking bench for icache_axi_read_bridge: directed scenarios plus randomized
// refills checked against a transaction-level model of the expected line return.
module tb_icache_axi_read_bridge;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 64;
    localparam int BEATS  = 2;

    logic              clock   = 1'b0;
    logic              reset   = 1'b1;
    logic              rd_req  = 1'b0;
    logic [ADDR_W-1:0] rd_addr = '0;
    logic              rd_rdy;
    logic              ret_valid;
    logic              ret_last;
    logic [DATA_W-1:0] ret_data;
    logic              arvalid;
    logic              arready = 1'b0;
    logic [ADDR_W-1:0] araddr;
    logic [3:0]        arid;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic              rvalid  = 1'b0;
    logic              rready;
    logic [DATA_W-1:0] rdata   = '0;
    logic [1:0]        rresp   = 2'b00;
    logic              rlast   = 1'b0;
    logic [3:0]        rid     = 4'd0;
    logic              bus_err;

    int n_tests = 0;
    int n_fail  = 0;
    bit err_exp = 1'b0;

    logic [DATA_W-1:0] beat_data  [BEATS];
    logic [1:0]        beat_resp  [BEATS];
    bit                beat_rlast [BEATS];

    icache_axi_read_bridge #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BEATS(BEATS), .AXI_ID(4'd0)
    ) dut (
        .clock(clock), .reset(reset),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
        .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid),
        .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
        .rlast(rlast), .rid(rid), .bus_err(bus_err)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clean_beats();
        for (int i = 0; i < BEATS; i++) begin
            beat_data[i]  = {$urandom, $urandom};
            beat_resp[i]  = 2'b00;
            beat_rlast[i] = (i == BEATS - 1);
        end
    endtask

    // One refill from an idle cycle to the cycle that presents ret_last (not stepped past).
    // Expected: aligned address, every beat up to the first rlast (or the BEATS-th) returned
    // one cycle after its handshake, last on the final one, bus_err sticky on any error.
    task automatic run_refill(input logic [31:0] addr, input int ar_delay, input int stall,
                              input bit spur);
        logic [31:0]       exp_addr;
        int                nb;
        bit                pv;
        bit                pl;
        logic [DATA_W-1:0] pd;
        exp_addr = addr & 32'hFFFF_FFF0;
        nb = BEATS;
        for (int i = 0; i < BEATS; i++) begin
            if (beat_rlast[i]) begin
                nb = i + 1;
                break;
            end
        end
        n_tests++;
        if (rd_rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL refill_idle_rdy: got %b expected 1", rd_rdy);
        end
        rd_req = 1'b1; rd_addr = addr;
        step();
        rd_req = 1'b0;
        for (int k = 0; k <= ar_delay; k++) begin
            n_tests++;
            if ({rd_rdy, arvalid, rready, ret_valid, araddr} !== {4'b0100, exp_addr}) begin
                n_fail++;
                $display("FAIL ar_phase: got rdy/arv/rrdy/rv=%b%b%b%b araddr=%h expected 0100 %h",
                         rd_rdy, arvalid, rready, ret_valid, araddr, exp_addr);
            end
            arready = (k == ar_delay);
            if (spur && k == 0) begin
                rd_req = 1'b1; rd_addr = ~addr;
            end
            step();
            arready = 1'b0; rd_req = 1'b0;
        end
        pv = 1'b0; pl = 1'b0; pd = '0;
        for (int b = 0; b < nb; b++) begin
            int s;
            s = (stall >= 0) ? stall : int'($urandom_range(0, 2));
            for (int j = 0; j <= s; j++) begin
                n_tests++;
                if ({rd_rdy, arvalid, rready, ret_valid} !== {3'b001, pv}) begin
                    n_fail++;
                    $display("FAIL r_phase: got rdy/arv/rrdy/rv=%b%b%b%b expected 001%b",
                             rd_rdy, arvalid, rready, ret_valid, pv);
                end
                if (pv) begin
                    n_tests++;
                    if ({ret_last, ret_data} !== {pl, pd}) begin
                        n_fail++;
                        $display("FAIL ret_beat: got last=%b data=%h expected last=%b data=%h",
                                 ret_last, ret_data, pl, pd);
                    end
                end
                if (spur && b == 0 && j == 0) begin
                    rd_req = 1'b1; rd_addr = ~addr;
                end
                rvalid = (j == s);
                if (j == s) begin
                    rdata = beat_data[b]; rresp = beat_resp[b]; rlast = beat_rlast[b];
                    pv = 1'b1; pd = beat_data[b]; pl = (b == nb - 1);
                    if (beat_resp[b] != 2'b00) err_exp = 1'b1;
                    if (b == BEATS - 1 && !beat_rlast[b]) err_exp = 1'b1;
                end else begin
                    rdata = {$urandom, $urandom}; rresp = 2'($urandom); rlast = 1'($urandom);
                    pv = 1'b0;
                end
                step();
                rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; rd_req = 1'b0;
            end
        end
        n_tests++;
        if ({rd_rdy, arvalid, rready, ret_valid, ret_last, ret_data, bus_err} !==
            {5'b10011, pd, err_exp}) begin
            n_fail++;
            $display("FAIL refill_end: got rdy/arv/rrdy/rv/rl=%b%b%b%b%b data=%h err=%b expected 10011 %h %b",
                     rd_rdy, arvalid, rready, ret_valid, ret_last, ret_data, bus_err, pd, err_exp);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(); step();
        n_tests++;
        if ({rd_rdy, arvalid, rready, ret_valid, ret_last, bus_err} !== 6'b100000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b%b%b%b%b%b expected 100000",
                     rd_rdy, arvalid, rready, ret_valid, ret_last, bus_err);
        end
        n_tests++;
        if ({araddr, ret_data} !== {32'h0, 64'h0}) begin
            n_fail++;
            $display("FAIL reset_data: got araddr=%h ret_data=%h expected 0 0", araddr, ret_data);
        end
        n_tests++;
        if ({arid, arlen, arsize, arburst} !== {4'd0, 8'd1, 3'd3, 2'b01}) begin
            n_fail++;
            $display("FAIL ar_consts: got id=%h len=%h size=%h burst=%h expected 0 01 3 1",
                     arid, arlen, arsize, arburst);
        end
        reset = 1'b0;
        err_exp = 1'b0;
        step();
    endtask

    task automatic test_basic();
        n_tests++;
        if (rd_rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_c0_rdy: got %b expected 1", rd_rdy);
        end
        rd_req = 1'b1; rd_addr = 32'h8000_1238;
        step();
        rd_req = 1'b0;
        n_tests++;
        if ({arvalid, rd_rdy, rready, araddr} !== {3'b100, 32'h8000_1230}) begin
            n_fail++;
            $display("FAIL basic_c1_ar: got arv/rdy/rrdy=%b%b%b araddr=%h expected 100 80001230",
                     arvalid, rd_rdy, rready, araddr);
        end
        n_tests++;
        if ({arid, arlen, arsize, arburst} !== {4'd0, 8'd1, 3'd3, 2'b01}) begin
            n_fail++;
            $display("FAIL basic_c1_attr: got id=%h len=%h size=%h burst=%h expected 0 01 3 1",
                     arid, arlen, arsize, arburst);
        end
        arready = 1'b1;
        step();
        arready = 1'b0;
        n_tests++;
        if ({rready, arvalid, ret_valid, rd_rdy} !== 4'b1000) begin
            n_fail++;
            $display("FAIL basic_c2: got rrdy/arv/rv/rdy=%b%b%b%b expected 1000",
                     rready, arvalid, ret_valid, rd_rdy);
        end
        rvalid = 1'b1; rdata = 64'h1111; rresp = 2'b00; rlast = 1'b0;
        step();
        n_tests++;
        if ({ret_valid, ret_last, rd_rdy, ret_data} !== {3'b100, 64'h1111}) begin
            n_fail++;
            $display("FAIL basic_c3: got rv/rl/rdy=%b%b%b data=%h expected 100 1111",
                     ret_valid, ret_last, rd_rdy, ret_data);
        end
        rdata = 64'h2222; rlast = 1'b1;
        step();
        rvalid = 1'b0; rlast = 1'b0;
        n_tests++;
        if ({ret_valid, ret_last, rd_rdy, bus_err, ret_data} !== {4'b1110, 64'h2222}) begin
            n_fail++;
            $display("FAIL basic_c4: got rv/rl/rdy/err=%b%b%b%b data=%h expected 1110 2222",
                     ret_valid, ret_last, rd_rdy, bus_err, ret_data);
        end
        step();
        n_tests++;
        if ({ret_valid, arvalid, rd_rdy} !== 3'b001) begin
            n_fail++;
            $display("FAIL basic_after: got rv/arv/rdy=%b%b%b expected 001", ret_valid, arvalid, rd_rdy);
        end
    endtask

    task automatic test_ar_backpressure();
        clean_beats();
        run_refill(32'h1234_567C, 5, 0, 1'b0);
        step();
    endtask

    task automatic test_r_stall_busy();
        logic [31:0] a;
        a = 32'hA5A5_0F07;
        clean_beats();
        run_refill(a, 1, 3, 1'b1);
        step();
        n_tests++;
        if ({rd_rdy, arvalid, ret_valid, araddr} !== {3'b100, 32'hA5A5_0F00}) begin
            n_fail++;
            $display("FAIL busy_req_ignored: got rdy/arv/rv=%b%b%b araddr=%h expected 100 a5a50f00",
                     rd_rdy, arvalid, ret_valid, araddr);
        end
        step();
        n_tests++;
        if (arvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL no_second_ar: got arvalid=%b expected 0", arvalid);
        end
    endtask

    task automatic test_error_no_last();
        // missing rlast alone
        clean_beats();
        beat_rlast[BEATS-1] = 1'b0;
        run_refill(32'h0000_4440, 0, 0, 1'b0);
        reset = 1'b1; step(); reset = 1'b0; err_exp = 1'b0;
        n_tests++;
        if (bus_err !== 1'b0) begin
            n_fail++;
            $display("FAIL err_reset_clear: got %b expected 0", bus_err);
        end
        // error response on beat 0 plus missing rlast
        clean_beats();
        beat_resp[0] = 2'b10;
        beat_rlast[BEATS-1] = 1'b0;
        run_refill(32'h0000_8888, 0, 1, 1'b0);
        step();
        n_tests++;
        if ({rd_rdy, bus_err} !== 2'b11) begin
            n_fail++;
            $display("FAIL err_idle: got rdy/err=%b%b expected 11", rd_rdy, bus_err);
        end
        clean_beats();
        run_refill(32'h0000_9990, 0, 0, 1'b0);
        step();
    endtask

    task automatic test_reset_mid_burst();
        rd_req = 1'b1; rd_addr = 32'h0BAD_F00D;
        step();
        rd_req = 1'b0; arready = 1'b1;
        step();
        arready = 1'b0;
        rvalid = 1'b1; rdata = 64'hDEAD_BEEF_0000_0001; rresp = 2'b10; rlast = 1'b0;
        step();
        rdata = 64'hDEAD_BEEF_0000_0002; rresp = 2'b00; rlast = 1'b1;
        reset = 1'b1;
        step();
        reset = 1'b0; rvalid = 1'b0; rlast = 1'b0; err_exp = 1'b0;
        n_tests++;
        if ({rd_rdy, rready, ret_valid, bus_err, arvalid} !== 5'b10000) begin
            n_fail++;
            $display("FAIL mid_reset: got rdy/rrdy/rv/err/arv=%b%b%b%b%b expected 10000",
                     rd_rdy, rready, ret_valid, bus_err, arvalid);
        end
        clean_beats();
        run_refill(32'h0000_2024, 2, 1, 1'b0);
        step();
    endtask

    task automatic test_back_to_back();
        clean_beats();
        run_refill(32'h4000_0010, 0, 0, 1'b0);
        clean_beats();
        run_refill(32'h4000_0ABC, 0, 0, 1'b0);
        clean_beats();
        run_refill(32'h4000_1FFF, 1, 0, 1'b0);
        step();
    endtask

    task automatic test_random();
        for (int it = 0; it < 40; it++) begin
            int idle;
            int mode;
            if (it == 20) begin
                reset = 1'b1; step(); reset = 1'b0; err_exp = 1'b0;
            end
            idle = $urandom_range(0, 2);
            for (int k = 0; k < idle; k++) begin
                step();
                n_tests++;
                if ({rd_rdy, arvalid, rready, ret_valid} !== 4'b1000) begin
                    n_fail++;
                    $display("FAIL rand_idle: got rdy/arv/rrdy/rv=%b%b%b%b expected 1000",
                             rd_rdy, arvalid, rready, ret_valid);
                end
            end
            clean_beats();
            mode = $urandom_range(0, 7);
            for (int i = 0; i < BEATS; i++) begin
                if ($urandom_range(0, 7) == 0) beat_resp[i] = 2'($urandom_range(1, 3));
            end
            if (mode == 0) beat_rlast[BEATS-1] = 1'b0;
            if (mode == 1) beat_rlast[0] = 1'b1;
            run_refill($urandom, $urandom_range(0, 3), -1, 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ar_backpressure();
        test_r_stall_busy();
        test_error_no_last();
        test_reset_mid_burst();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/icache_axi_read_bridge.md
# icache_axi_read_bridge

Converts the instruction cache's simple line-refill interface (rd_req/rd_addr → ret_valid/ret_last/ret_data) into a single-ID AXI4 INCR burst read. It sits directly downstream of the I-cache refill port and upstream of the AXI interconnect/arbiter. It handles one outstanding refill at a time and returns each beat to the cache one cycle after its R-channel handshake.

## Interface
- ADDR_W, 32, address width
- DATA_W, 64, AXI and return data width
- BEATS, 2, beats per cache line (line = BEATS*DATA_W/8 = 16 B)
- AXI_ID, 4'd0, constant arid value

- clock  in  1  clock
- reset  in  1  reset, synchronous, active-high
- rd_req  in  1  refill request pulse from the cache; sampled only while rd_rdy=1
- rd_addr  in  ADDR_W  refill line address
- rd_rdy  out  1  bridge idle; a request is accepted this cycle
- ret_valid  out  1  return beat valid (one-cycle pulse per beat)
- ret_last  out  1  qualifies ret_valid; final beat of the line
- ret_data  out  DATA_W  return beat data
- arvalid  out  1  AXI AR valid
- arready  in  1  AXI AR ready
- araddr  out  ADDR_W  line-aligned address
- arid  out  4  = AXI_ID
- arlen  out  8  = BEATS-1
- arsize  out  3  = log2(DATA_W/8), i.e. 3'd3 by default
- arburst  out  2  = 2'b01 (INCR)
- rvalid  in  1  AXI R valid
- rready  out  1  AXI R ready
- rdata  in  DATA_W  AXI R data
- rresp  in  2  AXI R response
- rlast  in  1  AXI R last
- rid  in  4  AXI R id; not checked
- bus_err  out  1  sticky; set by any beat with rresp != 2'b00

## Operation
- States: IDLE, AR, R.
- IDLE: rd_rdy=1. On rd_req=1, latch araddr = {rd_addr[ADDR_W-1:4], 4'b0} (low bits forced to line alignment), clear the beat counter, and go to AR.
- AR: arvalid=1, with araddr held stable until the handshake. On arvalid&&arready, go to R. The bridge never deasserts arvalid before the handshake.
- R: rready=1. Each rvalid&&rready beat:
  - registers rdata into ret_data;
  - pulses ret_valid on the next cycle;
  - increments the beat counter (width clog2(BEATS)+1).
- End of burst:
  - A beat with rlast=1 ends the burst: ret_last=1 with that beat's ret_valid, and the state returns to IDLE on the same edge.
  - If the counter reaches BEATS beats without rlast, the BEATS-th beat is also treated as last; the state returns to IDLE and bus_err is set.
- rd_req outside IDLE is ignored; rd_rdy=0 in AR and R.
- rresp != 0: data is still forwarded unchanged and bus_err is set. The only way to clear bus_err is reset.
- ret_data holds its last value between beats and is meaningful only while ret_valid=1.

## Timing
- Reset values: state=IDLE, rd_rdy=1, arvalid=0, araddr=0, rready=0, ret_valid=0, ret_last=0, ret_data=0, bus_err=0. arid, arlen, arsize and arburst are constants.
- Reset mid-burst: the bridge returns to IDLE at the next edge and drops arvalid/rready. Any in-flight R beats are not forwarded; the interconnect is reset in the same cycle.
- rd_rdy, arvalid and rready are decoded from state (registered state, no combinational input→output paths).
- Minimum latency, assuming arready and rvalid are both high immediately:
  - cycle 0: rd_req accepted;
  - cycle 1: arvalid, handshake;
  - cycle 2: rready, beat 0;
  - cycle 3: ret_valid for beat 0, beat 1 handshake;
  - cycle 4: ret_valid+ret_last, rd_rdy=1.
- rd_rdy returns high in the same cycle that ret_last is presented, so a back-to-back request is accepted there.
- R-channel stalls (rvalid=0) produce gaps in ret_valid; there is no buffering beyond the one data register.

## Test plan
- Basic refill: rd_req with rd_addr=0x8000_1238, arready=1, R beats 0x1111 then 0x2222 (rlast on the second) → araddr=0x8000_1230, arlen=1, arsize=3, arburst=1; ret_valid at cycles 3 and 4 with ret_data 0x1111 then 0x2222; ret_last only at cycle 4; rd_rdy=1 at cycle 4.
- AR backpressure: arready held low for 5 cycles → arvalid and araddr stable throughout, rd_rdy=0, rready=0 until the handshake.
- R stalls, and a request while busy: 3 idle cycles between beats, with rd_req pulsed during R → gap in ret_valid; the pulse is ignored (araddr unchanged, no second AR).
- Error and missing rlast: beat 0 with rresp=2'b10; beat 1 with rlast=0 → both beats forwarded, ret_last on beat 1, bus_err=1 sticky across a following clean refill, state=IDLE.
- Reset mid-burst: reset asserted after beat 0 → next cycle rd_rdy=1, rready=0, ret_valid=0, bus_err=0; a subsequent refill completes normally.
- Back-to-back: new rd_req in the ret_last cycle → accepted; arvalid the next cycle with the new aligned address.
